// File: rtl/pb_paddle_conditioner.sv
// PocketBeagle paddle input conditioner: sync, debounce, arbitrate
// up/down, and fault on a direction held too long.
module pb_paddle_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int STUCK_LIMIT     = 300000000,
   parameter int CNT_W           = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pb_up_raw,
   input  logic       pb_down_raw,
   output logic       up_cmd,
   output logic       down_cmd,
   output logic       link_fault,
   output logic       conflict,
   output logic [7:0] edge_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_UP,
      S_DOWN,
      S_BOTH,
      S_FAULT
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(STUCK_LIMIT - 1);

   logic [SYNC_STAGES-1:0] up_sync;
   logic [SYNC_STAGES-1:0] dn_sync;
   logic [1:0]             synced;
   logic [1:0]             stable;
   logic [1:0]             accept;
   logic [CNT_W-1:0]       db_cnt [2];
   logic [1:0]             n_acc;
   logic [8:0]             cnt_sum;
   logic                   su;
   logic                   sd;
   logic [CNT_W-1:0]       wd;
   state_t                 state;
   state_t                 nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         up_sync <= '0;
         dn_sync <= '0;
      end else begin
         up_sync <= {up_sync[SYNC_STAGES-2:0], pb_up_raw};
         dn_sync <= {dn_sync[SYNC_STAGES-2:0], pb_down_raw};
      end
   end

   assign synced = {dn_sync[SYNC_STAGES-1], up_sync[SYNC_STAGES-1]};

   always_comb begin
      accept = '0;
      for (int i = 0; i < 2; i++) begin
         accept[i] = (synced[i] != stable[i]) && (db_cnt[i] == DB_LAST);
      end
   end

   // Index 0 is the UP channel, index 1 the DOWN channel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (synced[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (accept[i]) begin
               stable[i] <= synced[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign n_acc   = {1'b0, accept[0]} + {1'b0, accept[1]};
   assign cnt_sum = {1'b0, edge_count} + {7'd0, n_acc};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_count <= '0;
      end else begin
         edge_count <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
      end
   end

   assign su = stable[0];
   assign sd = stable[1];

   // Release is checked before watchdog expiry so it wins a tie.
   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE: begin
            if (su && sd)    nxt = S_BOTH;
            else if (su)     nxt = S_UP;
            else if (sd)     nxt = S_DOWN;
         end
         S_UP: begin
            if (sd)               nxt = S_BOTH;
            else if (!su)         nxt = S_IDLE;
            else if (wd == WD_LAST) nxt = S_FAULT;
         end
         S_DOWN: begin
            if (su)               nxt = S_BOTH;
            else if (!sd)         nxt = S_IDLE;
            else if (wd == WD_LAST) nxt = S_FAULT;
         end
         S_BOTH: begin
            if (!(su && sd)) nxt = S_IDLE;
         end
         S_FAULT: begin
            if (!su && !sd) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         wd         <= '0;
         up_cmd     <= 1'b0;
         down_cmd   <= 1'b0;
         conflict   <= 1'b0;
         link_fault <= 1'b0;
      end else begin
         state <= nxt;
         if ((nxt == state) && (state == S_UP || state == S_DOWN)) begin
            wd <= wd + 1'b1;
         end else begin
            wd <= '0;
         end
         up_cmd     <= (nxt == S_UP);
         down_cmd   <= (nxt == S_DOWN);
         conflict   <= (nxt == S_BOTH);
         link_fault <= (nxt == S_FAULT);
      end
   end

endmodule
